i2c_slave_regfile: RTL and testbench
====================================

# i2c_slave_regfile

I2C target (slave) that answers the bus driven by our I2C master. It recognises its own 7-bit address, takes the register-address byte and the data bytes into a small on-chip register file, and ACKs on the bus. It sits directly downstream of the master on SCL/SDA, oversampled by the system clock. A host-side read port exposes the register contents to local logic.

## Interface
- SLAVE_ADDR, 7'h3C: 7-bit bus address this target answers to.
- REG_AW, 4: register file address width; depth is 2^REG_AW bytes.
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  synchronous, active-low reset.
- scl  input  1  bus clock, asynchronous to clk.
- sda  inout  1  bus data, open-drain: drives 1'b0 or 1'bz, never 1'b1.
- host_addr  input  REG_AW  host read address.
- host_rdata  output  8  regs[host_addr], registered.
- wr_strobe  output  1  one-clk pulse per register written from the bus.
- wr_addr  output  REG_AW  register index of the current wr_strobe.
- wr_data  output  8  byte written on the current wr_strobe.
- busy  output  1  high from START until STOP.

## Operation
- scl and sda each pass through a 2-flop synchroniser, then a third flop for edge detect. All bus events are evaluated on clk.
- START is sda falling while scl is high. It is accepted in any state: bit_cnt is cleared, the FSM goes to ADDR, and busy is set.
- STOP is sda rising while scl is high. The FSM goes to IDLE, busy is cleared, and sda is released. This is accepted in any state.
- Bits are sampled on the scl rising edge, MSB first. The bit counter runs 0..7 and wraps.
- FSM transitions:
  - IDLE: wait for START.
  - ADDR: collect 8 bits. If the 7 MSBs equal SLAVE_ADDR and the R/W bit is 0, go to ADDR_ACK. If R/W is 1, handling depends on the config macro. Otherwise go to IGNORE.
  - ADDR_ACK: pull sda low from the 8th scl fall to the 9th scl fall, then go to REG.
  - REG: collect 8 bits.
    - If the value is below 2^REG_AW, load ptr and go to REG_ACK, which behaves like ADDR_ACK.
    - If the value is 2^REG_AW or above, release sda for the 9th bit (NACK) and go to IGNORE.
  - WDATA: collect 8 bits, then write regs[ptr]. wr_strobe pulses for one clk with wr_addr=ptr and wr_data=byte. Go to WDATA_ACK, which ACKs.
    - After the ACK, ptr increments modulo 2^REG_AW (2^REG_AW-1 wraps to 0), then return to WDATA.
  - IGNORE: sda is released. Wait for START or STOP.
- sda is only ever changed on a detected scl falling edge, never while scl is high, except for the release on STOP/reset.
- Register file: 2^REG_AW × 8. Only the bus writes it. It is cleared to 0 on reset.

## Timing
- Reset (rst_n=0 at a clk edge):
  - Outputs: sda=z, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, host_rdata=0.
  - State: all registers 0, FSM in IDLE.
- Reset asserted mid-transfer aborts it immediately. The bus is released the next clk, and the target waits for a fresh START.
- Event latency: 3 clk from a pin edge to its detection. At 100 kHz SCL this is negligible.
- ACK drive timing:
  - sda goes low 1 clk after the detected scl fall that ends bit 8.
  - sda is released 1 clk after the detected scl fall that ends bit 9.
  - This gives hold of 3 clk or more after the true falling edge.
- wr_strobe is asserted 1 clk after the detected scl rise of data bit 0 (LSB).
- host_rdata shows regs[host_addr] 1 clk after host_addr is presented.
- Host read of the address being written in the same clk returns the old value. The new value appears on the next clk.
- START and STOP take priority over bit sampling in the same clk.

## Configuration
- I2C_SLAVE_READ_EN defined:
  - An address match with R/W=1 is ACKed and the FSM enters RDATA.
  - RDATA drives regs[ptr] MSB first: sda is pulled low for 0 bits and released for 1 bits, each bit changing on the scl fall.
  - After bit 8, sda is released and the master's ACK is sampled on the 9th scl rise.
  - ACK (low): ptr+1 with wrap, next byte.
  - NACK (high): IGNORE.
- I2C_SLAVE_READ_EN undefined:
  - R/W=1 is treated as a mismatch: NACK, then IGNORE.
  - The RDATA logic is absent.

## Test plan
- Write to 0x3C, reg 0x05, data 0xA7, STOP -> three ACKs. wr_strobe pulses once with wr_addr=5 and wr_data=0xA7. host_addr=5 reads 0xA7. busy returns to 0.
- Write to 0x3C, reg 0x0F, data 0x11, 0x22 -> regs[15]=0x11 and regs[0]=0x22 (pointer wrap). Two wr_strobe pulses.
- Address 0x3D, write -> sda stays z for the 9th bit (NACK). No wr_strobe, regs unchanged.
- Address 0x3C, reg 0x20 with REG_AW=4 -> address ACKed, register byte NACKed. A later data byte produces no write.
- Repeated START mid-data, then a write of reg 0x02 data 0x5A -> the first transfer is abandoned cleanly and regs[2]=0x5A. rst_n=0 during a data byte -> sda=z next clk, all regs 0.
- With I2C_SLAVE_READ_EN, regs[3]=0xC3: write reg 0x03, repeated START, read 2 bytes -> bus carries 0xC3 then regs[4]. NACK after the second byte -> sda released.

Source files
------------

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C target with a 2^REG_AW x 8 register file.
// Write-only by default. Defining I2C_SLAVE_READ_EN adds bus reads (RDATA/RACK).
// SCL/SDA are oversampled on clk. Each passes a 2-flop synchroniser plus one edge-detect flop.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h3C,
  parameter int         REG_AW     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl,
  inout  wire               sda,
  input  logic [REG_AW-1:0] host_addr,
  output logic [7:0]        host_rdata,
  output logic              wr_strobe,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam int                LP_NREG    = 2 ** REG_AW;
  localparam logic [8:0]        LP_DEPTH   = 9'(LP_NREG);
  localparam logic [REG_AW-1:0] LP_PTR_ONE = {{(REG_AW-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_REG       = 4'd3,
    ST_REG_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_IGNORE    = 4'd7,
    ST_RDATA     = 4'd8,
    ST_RACK      = 4'd9
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_scl_s1, r_scl_s2, r_scl_s3;
  logic                r_sda_s1, r_sda_s2, r_sda_s3;
  logic [2:0]          r_bit_cnt, w_bit_cnt_nxt;
  logic [6:0]          r_shift, w_shift_nxt;
  logic [REG_AW-1:0]   r_ptr, w_ptr_nxt;
  logic                r_sda_low, w_sda_low_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_wr_strobe, w_wr_strobe_nxt;
  logic [REG_AW-1:0]   r_wr_addr, w_wr_addr_nxt;
  logic [7:0]          r_wr_data, w_wr_data_nxt;
  logic                w_we;
  logic [7:0]          r_regs [LP_NREG];
  logic [7:0]          r_host_rdata;
  logic                w_scl_rise, w_scl_fall, w_start, w_stop;
  logic                w_collect, w_byte_done, w_addr_hit;
  logic [7:0]          w_byte;
`ifdef I2C_SLAVE_READ_EN
  logic                r_rw, w_rw_nxt;
  logic [7:0]          w_rd_byte;
  assign w_rd_byte = r_regs[r_ptr];
  assign w_collect = (r_state == ST_ADDR) || (r_state == ST_REG) ||
                     (r_state == ST_WDATA) || (r_state == ST_RDATA);
`else
  assign w_collect = (r_state == ST_ADDR) || (r_state == ST_REG) || (r_state == ST_WDATA);
`endif

  // Bus events, all seen on synchronised copies of the pins
  assign w_scl_rise  = r_scl_s2 & ~r_scl_s3;
  assign w_scl_fall  = ~r_scl_s2 & r_scl_s3;
  assign w_start     = r_scl_s2 & ~r_sda_s2 & r_sda_s3;
  assign w_stop      = r_scl_s2 & r_sda_s2 & ~r_sda_s3;
  assign w_byte      = {r_shift, r_sda_s2};
  assign w_byte_done = w_scl_rise & (r_bit_cnt == 3'd7);
  assign w_addr_hit  = (w_byte[7:1] == SLAVE_ADDR);

  // Open drain: only ever pull low or let go
  assign sda        = r_sda_low ? 1'b0 : 1'bz;
  assign host_rdata = r_host_rdata;
  assign wr_strobe  = r_wr_strobe;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign busy       = r_busy;

  // Synchronise SCL/SDA and keep one extra stage for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {r_scl_s1, r_scl_s2, r_scl_s3} <= 3'b000;
      {r_sda_s1, r_sda_s2, r_sda_s3} <= 3'b000;
    end else begin
      {r_scl_s1, r_scl_s2, r_scl_s3} <= {scl, r_scl_s1, r_scl_s2};
      {r_sda_s1, r_sda_s2, r_sda_s3} <= {sda, r_sda_s1, r_sda_s2};
    end
  end

  // Protocol FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 7'd0;
      r_ptr       <= '0;
      r_sda_low   <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= 8'd0;
`ifdef I2C_SLAVE_READ_EN
      r_rw        <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_ptr       <= w_ptr_nxt;
      r_sda_low   <= w_sda_low_nxt;
      r_busy      <= w_busy_nxt;
      r_wr_strobe <= w_wr_strobe_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
`ifdef I2C_SLAVE_READ_EN
      r_rw        <= w_rw_nxt;
`endif
    end
  end

  // Next-state logic; START/STOP override bit sampling in the same clk
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_ptr_nxt       = r_ptr;
    w_sda_low_nxt   = r_sda_low;
    w_busy_nxt      = r_busy;
    w_wr_strobe_nxt = 1'b0;
    w_wr_addr_nxt   = r_wr_addr;
    w_wr_data_nxt   = r_wr_data;
    w_we            = 1'b0;
`ifdef I2C_SLAVE_READ_EN
    w_rw_nxt        = r_rw;
`endif
    if (w_start) begin
      w_state_nxt   = ST_ADDR;
      w_bit_cnt_nxt = 3'd0;
      w_busy_nxt    = 1'b1;
      w_sda_low_nxt = 1'b0;
    end else if (w_stop) begin
      w_state_nxt   = ST_IDLE;
      w_bit_cnt_nxt = 3'd0;
      w_busy_nxt    = 1'b0;
      w_sda_low_nxt = 1'b0;
    end else begin
      if (w_scl_rise && w_collect) begin
        w_shift_nxt   = w_byte[6:0];
        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
      end else begin
        w_bit_cnt_nxt = r_bit_cnt;
      end
      case (r_state)
        ST_IDLE, ST_IGNORE: w_state_nxt = r_state;
        ST_ADDR: begin
          if (w_byte_done) begin
            if (w_addr_hit && !w_byte[0]) begin
              w_state_nxt = ST_ADDR_ACK;
`ifdef I2C_SLAVE_READ_EN
              w_rw_nxt    = 1'b0;
            end else if (w_addr_hit) begin
              w_state_nxt = ST_ADDR_ACK;
              w_rw_nxt    = 1'b1;
`endif
            end else begin
              w_state_nxt = ST_IGNORE;
            end
          end else begin
            w_state_nxt = r_state;
          end
        end
        // First fall after the byte starts the ACK, second fall ends it
        ST_ADDR_ACK: begin
          if (w_scl_fall && !r_sda_low) begin
            w_sda_low_nxt = 1'b1;
          end else if (w_scl_fall) begin
`ifdef I2C_SLAVE_READ_EN
            if (r_rw) begin
              w_state_nxt   = ST_RDATA;
              w_sda_low_nxt = ~w_rd_byte[7];
            end else begin
              w_state_nxt   = ST_REG;
              w_sda_low_nxt = 1'b0;
            end
`else
            w_state_nxt   = ST_REG;
            w_sda_low_nxt = 1'b0;
`endif
          end else begin
            w_state_nxt = r_state;
          end
        end
        ST_REG: begin
          if (w_byte_done && ({1'b0, w_byte} < LP_DEPTH)) begin
            w_ptr_nxt   = w_byte[REG_AW-1:0];
            w_state_nxt = ST_REG_ACK;
          end else if (w_byte_done) begin
            w_state_nxt = ST_IGNORE;
          end else begin
            w_state_nxt = r_state;
          end
        end
        ST_REG_ACK: begin
          if (w_scl_fall && !r_sda_low) begin
            w_sda_low_nxt = 1'b1;
          end else if (w_scl_fall) begin
            w_sda_low_nxt = 1'b0;
            w_state_nxt   = ST_WDATA;
          end else begin
            w_state_nxt = r_state;
          end
        end
        ST_WDATA: begin
          if (w_byte_done) begin
            w_we            = 1'b1;
            w_wr_strobe_nxt = 1'b1;
            w_wr_addr_nxt   = r_ptr;
            w_wr_data_nxt   = w_byte;
            w_state_nxt     = ST_WDATA_ACK;
          end else begin
            w_state_nxt = r_state;
          end
        end
        ST_WDATA_ACK: begin
          if (w_scl_fall && !r_sda_low) begin
            w_sda_low_nxt = 1'b1;
          end else if (w_scl_fall) begin
            w_sda_low_nxt = 1'b0;
            w_ptr_nxt     = r_ptr + LP_PTR_ONE;
            w_state_nxt   = ST_WDATA;
          end else begin
            w_state_nxt = r_state;
          end
        end
`ifdef I2C_SLAVE_READ_EN
        // Next bit goes out on each fall; after bit 0 hand SDA back to the master
        ST_RDATA: begin
          if (w_scl_rise && (r_bit_cnt == 3'd7)) begin
            w_state_nxt = ST_RACK;
          end else if (w_scl_fall) begin
            w_sda_low_nxt = ~w_rd_byte[3'd7 - r_bit_cnt];
          end else begin
            w_state_nxt = r_state;
          end
        end
        ST_RACK: begin
          if (w_scl_fall) begin
            w_sda_low_nxt = 1'b0;
          end else if (w_scl_rise && !r_sda_s2) begin
            w_ptr_nxt   = r_ptr + LP_PTR_ONE;
            w_state_nxt = ST_RDATA;
          end else if (w_scl_rise) begin
            w_state_nxt = ST_IGNORE;
          end else begin
            w_state_nxt = r_state;
          end
        end
`endif
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Register file: bus write port, registered host read port (read-before-write)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LP_NREG; i++) r_regs[i] <= 8'd0;
      r_host_rdata <= 8'd0;
    end else begin
      if (w_we) r_regs[r_ptr] <= w_byte;
      r_host_rdata <= r_regs[host_addr];
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: a bit-banged I2C master drives the DUT.
// A register-array model predicts ACKs, write strobes and register contents.
// Read transfers are exercised only when I2C_SLAVE_READ_EN is defined.
module tb_i2c_slave_regfile;

  localparam int Q = 6;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda_low = 1'b0;
  wire        sda;
  logic [3:0] host_addr = 4'd0;
  logic [7:0] host_rdata;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_slave_regfile #(.SLAVE_ADDR(7'h3C), .REG_AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
    .host_addr(host_addr), .host_rdata(host_rdata),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  mdl [16];
  logic [11:0] exp_q [$];
  logic [11:0] mon_q [$];
  logic [7:0]  tb_data [8];

  // Record every write strobe the DUT issues
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) mon_q.push_back({wr_addr, wr_data});
  end

  // Guard against a stuck run
  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; wq(Q);
    scl = 1'b1;       wq(Q);
    m_sda_low = 1'b1; wq(Q);
    scl = 1'b0;       wq(Q);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wq(Q);
    scl = 1'b1;       wq(Q);
    m_sda_low = 1'b0; wq(Q);
  endtask

  task automatic clock_bit(input logic b);
    m_sda_low = ~b; wq(Q);
    scl = 1'b1;     wq(2 * Q);
    scl = 1'b0;     wq(Q);
  endtask

  // Ninth clock with SDA released; returns the level seen (0 = ACK)
  task automatic ack_bit(output logic seen);
    m_sda_low = 1'b0; wq(Q);
    scl = 1'b1;       wq(Q);
    seen = sda;       wq(Q);
    scl = 1'b0;       wq(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic seen);
    for (int i = 7; i >= 0; i--) clock_bit(b[i]);
    ack_bit(seen);
  endtask

  // Full write transfer; expectations come from the register-array model
  task automatic xfer(input logic [6:0] a, input logic rw, input logic [7:0] r, input int n);
    logic       seen;
    logic       addr_ok, reg_ok;
    logic [3:0] p;
    addr_ok = (a == 7'h3C) && !rw;
    reg_ok  = addr_ok && (r < 8'd16);
    p = r[3:0];
    i2c_start();
    chk("busy_after_start", busy, 1'b1);
    send_byte({a, rw}, seen);
    chk("addr_ack", seen, addr_ok ? 1'b0 : 1'b1);
    send_byte(r, seen);
    chk("reg_ack", seen, reg_ok ? 1'b0 : 1'b1);
    for (int i = 0; i < n; i++) begin
      send_byte(tb_data[i], seen);
      chk("data_ack", seen, reg_ok ? 1'b0 : 1'b1);
      if (reg_ok) begin
        mdl[p] = tb_data[i];
        exp_q.push_back({p, tb_data[i]});
        p = p + 4'd1;
      end
    end
    i2c_stop();
    wq(4);
    chk("busy_after_stop", busy, 1'b0);
    chk("sda_idle", sda, 1'b1);
  endtask

  task automatic chk_strobes();
    chk("wr_count", 16'(mon_q.size()), 16'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
      chk("wr_addr_data", mon_q[i], exp_q[i]);
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_regs();
    for (int i = 0; i < 16; i++) begin
      host_addr = 4'(i);
      wq(2);
      chk("host_rdata", host_rdata, mdl[i]);
    end
  endtask

`ifdef I2C_SLAVE_READ_EN
  task automatic read_byte(output logic [7:0] b);
    m_sda_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      wq(Q);
      scl = 1'b1; wq(Q);
      b[i] = sda; wq(Q);
      scl = 1'b0; wq(Q);
    end
  endtask

  task automatic master_ack(input logic ack);
    m_sda_low = ack; wq(Q);
    scl = 1'b1;      wq(2 * Q);
    scl = 1'b0;      wq(Q);
    m_sda_low = 1'b0;
  endtask
`endif

  initial begin
    logic       seen;
    logic [7:0] d;
    logic [6:0] a;
    logic [7:0] r;
    int         n;
    for (int i = 0; i < 16; i++) mdl[i] = 8'd0;

    // Reset state
    wq(4);
    chk("rst_sda", sda, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_strobe", wr_strobe, 1'b0);
    chk("rst_wr_addr", wr_addr, 4'd0);
    chk("rst_wr_data", wr_data, 8'd0);
    chk("rst_host_rdata", host_rdata, 8'd0);
    rst_n = 1'b1;
    wq(8);

    // Single write: reg 5 <= A7
    tb_data[0] = 8'hA7;
    xfer(7'h3C, 1'b0, 8'h05, 1);
    chk_strobes();
    chk_regs();

    // Pointer wrap: reg 15 <= 11, reg 0 <= 22
    tb_data[0] = 8'h11; tb_data[1] = 8'h22;
    xfer(7'h3C, 1'b0, 8'h0F, 2);
    chk_strobes();

    // Wrong address: NACK, nothing written
    tb_data[0] = 8'h99;
    xfer(7'h3D, 1'b0, 8'h01, 1);
    chk_strobes();

    // Register index out of range: address ACK, register NACK, no write
    tb_data[0] = 8'h55;
    xfer(7'h3C, 1'b0, 8'h20, 1);
    chk_strobes();
    chk_regs();

    // Repeated START part-way through a data byte, then a clean write
    i2c_start();
    send_byte({7'h3C, 1'b0}, seen);
    chk("rs_addr_ack", seen, 1'b0);
    send_byte(8'h07, seen);
    chk("rs_reg_ack", seen, 1'b0);
    for (int i = 0; i < 4; i++) clock_bit(1'b1);
    tb_data[0] = 8'h5A;
    xfer(7'h3C, 1'b0, 8'h02, 1);
    chk_strobes();
    chk_regs();

`ifdef I2C_SLAVE_READ_EN
    // Write reg 3/4, repeated START, read two bytes back
    tb_data[0] = 8'hC3; tb_data[1] = 8'($urandom);
    xfer(7'h3C, 1'b0, 8'h03, 2);
    chk_strobes();
    i2c_start();
    send_byte({7'h3C, 1'b0}, seen);
    chk("rd_waddr_ack", seen, 1'b0);
    send_byte(8'h03, seen);
    chk("rd_reg_ack", seen, 1'b0);
    i2c_start();
    send_byte({7'h3C, 1'b1}, seen);
    chk("rd_addr_ack", seen, 1'b0);
    read_byte(d);
    chk("rd_byte0", d, mdl[3]);
    master_ack(1'b1);
    read_byte(d);
    chk("rd_byte1", d, mdl[4]);
    master_ack(1'b0);
    wq(Q);
    chk("rd_nack_release", sda, 1'b1);
    i2c_stop();
    wq(4);
    chk("rd_busy_after_stop", busy, 1'b0);
`else
    // Read request without read support: NACK and ignore
    tb_data[0] = 8'h66;
    xfer(7'h3C, 1'b1, 8'h04, 1);
    chk_strobes();
`endif

    // Randomised transfers against the model
    for (int t = 0; t < 6; t++) begin
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'h3C;
      r = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) tb_data[i] = 8'($urandom);
      xfer(a, 1'b0, r, n);
      chk_strobes();
    end
    chk_regs();

    // Reset while the target holds a data ACK
    d = 8'($urandom);
    i2c_start();
    send_byte({7'h3C, 1'b0}, seen);
    chk("rst_case_addr_ack", seen, 1'b0);
    send_byte(8'h09, seen);
    chk("rst_case_reg_ack", seen, 1'b0);
    for (int i = 7; i >= 0; i--) clock_bit(d[i]);
    m_sda_low = 1'b0;
    wq(1);
    chk("ack_driven_low", sda, 1'b0);
    exp_q.push_back({4'd9, d});
    chk_strobes();
    rst_n = 1'b0;
    wq(1);
    chk("rst_sda_release", sda, 1'b1);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_wr_addr", wr_addr, 4'd0);
    chk("rst_mid_wr_data", wr_data, 8'd0);
    wq(1);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) mdl[i] = 8'd0;
    scl = 1'b1;
    wq(8);
    chk_regs();

    // Recovery after reset
    tb_data[0] = 8'($urandom);
    xfer(7'h3C, 1'b0, 8'h01, 1);
    chk_strobes();
    chk_regs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
